// File: rtl/sweep_pkg.sv
// Shared types and defaults for the step-value sweep controller.
package sweep_pkg;

   localparam int unsigned SWEEP_W  = 11;
   localparam int unsigned SWEEP_DW = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } state_t;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_TRI     = 1'b1;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module dwell_timer
   import sweep_pkg::*;
#(
   parameter int unsigned DW = SWEEP_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] load_val,
   output logic          expire
);

   logic [DW-1:0] cnt;

   // Count register: load has priority, otherwise count down and hold at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - DW'(1);
      end
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// Linear sweep generator producing the step value and enable for the
// downstream step accumulator; one-shot up-ramp or continuous triangle.
module sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int unsigned W  = SWEEP_W,
   parameter int unsigned DW = SWEEP_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stop,
   input  logic          mode,
   input  logic [W-1:0]  m_min,
   input  logic [W-1:0]  m_max,
   input  logic [W-1:0]  m_inc,
   input  logic [DW-1:0] dwell,
   output logic [W-1:0]  m,
   output logic          enb,
   output logic          busy,
   output logic          done,
   output logic          err
);

   state_t        state, state_n;
   logic [W-1:0]  m_n;
   logic          enb_n, busy_n, done_n, err_n;

   logic [W-1:0]  min_lat, max_lat, inc_lat;
   logic [W-1:0]  min_lat_n, max_lat_n, inc_lat_n;
   logic [DW-1:0] dw_lat, dw_lat_n;
   logic          mode_lat, mode_lat_n;

   logic          load;
   logic [DW-1:0] load_val;
   logic          expire;

   logic [DW-1:0]       dwell_eff;
   logic                cfg_ok;
   logic [W:0]          up_sum;
   logic [W-1:0]        up_val;
   logic signed [W:0]   dn_diff;
   logic [W-1:0]        dn_val;

   dwell_timer #(.DW(DW)) u_dwell (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .expire   (expire)
   );

   // State, outputs and latched sweep configuration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         m        <= '0;
         enb      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         min_lat  <= '0;
         max_lat  <= '0;
         inc_lat  <= '0;
         dw_lat   <= '0;
         mode_lat <= MODE_ONESHOT;
      end else begin
         state    <= state_n;
         m        <= m_n;
         enb      <= enb_n;
         busy     <= busy_n;
         done     <= done_n;
         err      <= err_n;
         min_lat  <= min_lat_n;
         max_lat  <= max_lat_n;
         inc_lat  <= inc_lat_n;
         dw_lat   <= dw_lat_n;
         mode_lat <= mode_lat_n;
      end
   end

   // Next state, clamped step arithmetic and dwell reload control.
   always_comb begin
      state_n    = state;
      m_n        = m;
      enb_n      = enb;
      busy_n     = busy;
      done_n     = 1'b0;
      err_n      = 1'b0;
      min_lat_n  = min_lat;
      max_lat_n  = max_lat;
      inc_lat_n  = inc_lat;
      dw_lat_n   = dw_lat;
      mode_lat_n = mode_lat;
      load       = 1'b0;
      load_val   = dw_lat - DW'(1);

      dwell_eff = (dwell == '0) ? DW'(1) : dwell;
      cfg_ok    = (m_min <= m_max) && (m_inc != '0);

      // Extra bit on both sides so overflow/underflow clamps instead of wrapping.
      up_sum  = {1'b0, m} + {1'b0, inc_lat};
      up_val  = (up_sum >= {1'b0, max_lat}) ? max_lat : up_sum[W-1:0];
      dn_diff = $signed({1'b0, m}) - $signed({1'b0, inc_lat});
      dn_val  = (dn_diff <= $signed({1'b0, min_lat})) ? min_lat : dn_diff[W-1:0];

      case (state)
         IDLE: begin
            if (!stop && start) begin
               if (cfg_ok) begin
                  state_n    = UP;
                  m_n        = m_min;
                  enb_n      = 1'b1;
                  busy_n     = 1'b1;
                  min_lat_n  = m_min;
                  max_lat_n  = m_max;
                  inc_lat_n  = m_inc;
                  dw_lat_n   = dwell_eff;
                  mode_lat_n = mode;
                  load       = 1'b1;
                  load_val   = dwell_eff - DW'(1);
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         UP: begin
            if (stop) begin
               state_n = IDLE;
               m_n     = '0;
               enb_n   = 1'b0;
               busy_n  = 1'b0;
            end else if (expire) begin
               load = 1'b1;
               if (m == max_lat) begin
                  if (mode_lat == MODE_ONESHOT) begin
                     state_n = IDLE;
                     m_n     = '0;
                     enb_n   = 1'b0;
                     busy_n  = 1'b0;
                     done_n  = 1'b1;
                  end else begin
                     state_n = DOWN;
                     m_n     = dn_val;
                  end
               end else begin
                  m_n = up_val;
               end
            end
         end
         DOWN: begin
            if (stop) begin
               state_n = IDLE;
               m_n     = '0;
               enb_n   = 1'b0;
               busy_n  = 1'b0;
            end else if (expire) begin
               load = 1'b1;
               // Leaving the bottom steps up at once so m_min is held only one dwell.
               if (m == min_lat) begin
                  state_n = UP;
                  m_n     = up_val;
               end else begin
                  m_n = dn_val;
               end
            end
         end
         default: begin
            state_n = IDLE;
            m_n     = '0;
            enb_n   = 1'b0;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed, table-driven check of the sweep controller.
module tb_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        mode = 1'b0;
   logic [10:0] m_min = '0;
   logic [10:0] m_max = '0;
   logic [10:0] m_inc = '0;
   logic [15:0] dwell = '0;
   logic [10:0] m;
   logic        enb, busy, done, err;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic        start;
      logic        stop;
      logic        mode;
      logic [10:0] mn;
      logic [10:0] mx;
      logic [10:0] inc;
      logic [15:0] dw;
      logic [10:0] em;
      logic        ee;
      logic        eb;
      logic        ed;
      logic        er;
      string       name;
   } vec_t;

   vec_t vecs[$];

   sweep_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .stop  (stop),
      .mode  (mode),
      .m_min (m_min),
      .m_max (m_max),
      .m_inc (m_inc),
      .dwell (dwell),
      .m     (m),
      .enb   (enb),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic st, input logic sp, input logic md,
                               input int mn, input int mx, input int inc, input int dw,
                               input int em, input logic ee, input logic eb,
                               input logic ed, input logic er, input string name);
      vec_t v;
      v.start = st; v.stop = sp; v.mode = md;
      v.mn = 11'(mn); v.mx = 11'(mx); v.inc = 11'(inc); v.dw = 16'(dw);
      v.em = 11'(em); v.ee = ee; v.eb = eb; v.ed = ed; v.er = er;
      v.name = name;
      return v;
   endfunction

   task automatic check(input string name, input logic [10:0] em, input logic ee,
                        input logic eb, input logic ed, input logic er);
      compared++;
      if ({m, enb, busy, done, err} !== {em, ee, eb, ed, er}) begin
         mismatched++;
         $display("FAIL %s: got m=%0d enb=%b busy=%b done=%b err=%b, want m=%0d enb=%b busy=%b done=%b err=%b",
                  name, m, enb, busy, done, err, em, ee, eb, ed, er);
      end
   endtask

   task automatic drive(input logic st, input logic sp, input logic md,
                        input int mn, input int mx, input int inc, input int dw);
      start = st; stop = sp; mode = md;
      m_min = 11'(mn); m_max = 11'(mx); m_inc = 11'(inc); dwell = 16'(dw);
   endtask

   initial begin
      // One-shot: 10..30 step 10, dwell 2
      vecs.push_back(mk(1, 0, 0, 10, 30, 10, 2, 10, 1, 1, 0, 0, "os_start"));
      vecs.push_back(mk(0, 0, 0, 10, 30, 10, 2, 10, 1, 1, 0, 0, "os_c2"));
      vecs.push_back(mk(0, 0, 0, 10, 30, 10, 2, 20, 1, 1, 0, 0, "os_c3"));
      vecs.push_back(mk(0, 0, 0, 10, 30, 10, 2, 20, 1, 1, 0, 0, "os_c4"));
      vecs.push_back(mk(0, 0, 0, 10, 30, 10, 2, 30, 1, 1, 0, 0, "os_c5"));
      vecs.push_back(mk(0, 0, 0, 10, 30, 10, 2, 30, 1, 1, 0, 0, "os_c6"));
      vecs.push_back(mk(0, 0, 0, 10, 30, 10, 2,  0, 0, 0, 1, 0, "os_done"));
      vecs.push_back(mk(0, 0, 0, 10, 30, 10, 2,  0, 0, 0, 0, 0, "os_done_once"));
      // Invalid configs and start+stop in IDLE
      vecs.push_back(mk(1, 0, 0, 50, 40, 10, 2,  0, 0, 0, 0, 1, "bad_minmax"));
      vecs.push_back(mk(0, 0, 0, 50, 40, 10, 2,  0, 0, 0, 0, 0, "bad_err_once"));
      vecs.push_back(mk(1, 0, 0, 10, 30,  0, 2,  0, 0, 0, 0, 1, "bad_inc0"));
      vecs.push_back(mk(0, 0, 0, 10, 30, 10, 2,  0, 0, 0, 0, 0, "bad_inc0_once"));
      vecs.push_back(mk(1, 1, 0, 10, 30, 10, 2,  0, 0, 0, 0, 0, "idle_start_stop"));
      vecs.push_back(mk(0, 0, 0, 10, 30, 10, 2,  0, 0, 0, 0, 0, "idle_after_ss"));
      // Abort during m = 20
      vecs.push_back(mk(1, 0, 0, 10, 30, 10, 2, 10, 1, 1, 0, 0, "ab_start"));
      vecs.push_back(mk(0, 0, 0, 10, 30, 10, 2, 10, 1, 1, 0, 0, "ab_c2"));
      vecs.push_back(mk(0, 0, 0, 10, 30, 10, 2, 20, 1, 1, 0, 0, "ab_c3"));
      vecs.push_back(mk(0, 1, 0, 10, 30, 10, 2,  0, 0, 0, 0, 0, "ab_stop"));
      vecs.push_back(mk(0, 0, 0, 10, 30, 10, 2,  0, 0, 0, 0, 0, "ab_idle"));
      // Triangle 0..25 step 10, dwell 0 -> 1; start and m_max change while busy ignored
      vecs.push_back(mk(1, 0, 1,  0, 25, 10, 0,  0, 1, 1, 0, 0, "tri_start"));
      vecs.push_back(mk(0, 0, 1,  0, 25, 10, 0, 10, 1, 1, 0, 0, "tri_10"));
      vecs.push_back(mk(1, 0, 0,  0,  5,  3, 7, 20, 1, 1, 0, 0, "tri_busy_start"));
      vecs.push_back(mk(0, 0, 0,  0,  5,  3, 7, 25, 1, 1, 0, 0, "tri_top"));
      vecs.push_back(mk(0, 0, 1,  0, 25, 10, 0, 15, 1, 1, 0, 0, "tri_15"));
      vecs.push_back(mk(0, 0, 1,  0, 25, 10, 0,  5, 1, 1, 0, 0, "tri_5"));
      vecs.push_back(mk(0, 0, 1,  0, 25, 10, 0,  0, 1, 1, 0, 0, "tri_bot"));
      vecs.push_back(mk(0, 0, 1,  0, 25, 10, 0, 10, 1, 1, 0, 0, "tri_10b"));
      vecs.push_back(mk(0, 0, 1,  0, 25, 10, 0, 20, 1, 1, 0, 0, "tri_20b"));
      vecs.push_back(mk(0, 0, 1,  0, 25, 10, 0, 25, 1, 1, 0, 0, "tri_topb"));
      vecs.push_back(mk(0, 0, 1,  0, 25, 10, 0, 15, 1, 1, 0, 0, "tri_15b"));
      vecs.push_back(mk(0, 1, 1,  0, 25, 10, 0,  0, 0, 0, 0, 0, "tri_stop"));
      // Overflow clamp: 2000, 2040, 2047, done
      vecs.push_back(mk(1, 0, 0, 2000, 2047, 40, 1, 2000, 1, 1, 0, 0, "ov_start"));
      vecs.push_back(mk(0, 0, 0, 2000, 2047, 40, 1, 2040, 1, 1, 0, 0, "ov_2040"));
      vecs.push_back(mk(0, 0, 0, 2000, 2047, 40, 1, 2047, 1, 1, 0, 0, "ov_clamp"));
      vecs.push_back(mk(0, 0, 0, 2000, 2047, 40, 1,    0, 0, 0, 1, 0, "ov_done"));
      vecs.push_back(mk(0, 0, 0, 2000, 2047, 40, 1,    0, 0, 0, 0, 0, "ov_idle"));
      // m_min == m_max, one-shot, dwell 3: held three cycles then done
      vecs.push_back(mk(1, 0, 0, 7, 7, 1, 3, 7, 1, 1, 0, 0, "eq_start"));
      vecs.push_back(mk(0, 0, 0, 7, 7, 1, 3, 7, 1, 1, 0, 0, "eq_c2"));
      vecs.push_back(mk(0, 0, 0, 7, 7, 1, 3, 7, 1, 1, 0, 0, "eq_c3"));
      vecs.push_back(mk(0, 0, 0, 7, 7, 1, 3, 0, 0, 0, 1, 0, "eq_done"));

      // Reset state while rst_n held low
      #2;
      check("reset_state", 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         drive(vecs[i].start, vecs[i].stop, vecs[i].mode, int'(vecs[i].mn),
               int'(vecs[i].mx), int'(vecs[i].inc), int'(vecs[i].dw));
         @(posedge clk);
         #1;
         check(vecs[i].name, vecs[i].em, vecs[i].ee, vecs[i].eb, vecs[i].ed, vecs[i].er);
      end

      // Asynchronous reset mid-triangle at m = 20
      drive(1, 0, 1, 0, 25, 10, 0);
      @(posedge clk); #1;
      drive(0, 0, 1, 0, 25, 10, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_reset_m20", 11'd20, 1'b1, 1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("reset_held", 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("after_reset_idle", 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Stop coinciding with one-shot completion: no done
      drive(1, 0, 0, 5, 5, 1, 1);
      @(posedge clk); #1;
      check("sc_start", 11'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(0, 1, 0, 5, 5, 1, 1);
      @(posedge clk); #1;
      check("sc_stop_wins", 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(0, 0, 0, 5, 5, 1, 1);
      @(posedge clk); #1;
      check("sc_no_late_done", 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
- Upstream stage of the step accumulator (consumes `m[10:0]` and `enb`, produces running sum `s`).
- Generates the accumulator's step value `m` and its `enb` gate as a programmable linear sweep between `m_min` and `m_max`.
- Two sweep modes: one-shot ramp-up, or continuous triangle.
- `enb` low clears the downstream accumulator, so this block also controls when accumulation starts and stops.

Parameters:
- W, 11, width of step values (`m`, `m_min`, `m_max`, `m_inc`).
- DW, 16, width of the dwell counter and the `dwell` input.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- stop  in  1  one-cycle pulse; aborts the sweep.
- mode  in  1  0 = one-shot up-ramp; 1 = continuous triangle.
- m_min  in  W  lower sweep bound.
- m_max  in  W  upper sweep bound.
- m_inc  in  W  step increment per dwell period.
- dwell  in  DW  cycles each m value is held; 0 is treated as 1.
- m  out  W  step value to the accumulator.
- enb  out  1  accumulator enable.
- busy  out  1  high in any sweep state.
- done  out  1  one-cycle pulse at natural one-shot completion.
- err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Interface: one clock (`clk`); reset is asynchronous and active-low (`rst_n`).
- Reset (async, any state): state = IDLE; m = 0, enb = 0, busy = 0, done = 0, err = 0; dwell counter = 0.
- All outputs are registered.
- States:
  - IDLE: m = 0, enb = 0.
  - UP: m rising.
  - DOWN: m falling.
- Config latch:
  - On accepted start, latch m_min, m_max, m_inc, mode and dwell (0 -> 1).
  - Input changes during a sweep are ignored.
- Start acceptance:
  - start sampled high in IDLE at edge k, with a valid config -> at edge k: m = m_min, enb = 1, busy = 1, state = UP, dwell counter = dwell_eff - 1.
  - m is therefore visible in the cycle after the start pulse.
- Invalid config: m_min > m_max or m_inc == 0.
  - start is rejected: err = 1 for one cycle, state stays IDLE.
- start while busy: ignored.
- Dwell: each m value is held exactly dwell_eff cycles. The counter decrements each cycle; a step occurs on the edge where counter == 0, and the counter reloads dwell_eff - 1.
- UP step:
  - Compute nxt = m + m_inc in W+1 bits.
  - If nxt >= m_max: m = m_max, and the next step leaves the top.
  - Otherwise m = nxt.
  - Overflow past 2^W - 1 clamps to m_max; no wrap.
- Leaving the top (m == m_max and dwell expired):
  - mode 0: state = IDLE, m = 0, enb = 0, busy = 0, done = 1 for one cycle.
  - mode 1: state = DOWN; m = m_max - m_inc, clamped to m_min.
- DOWN step:
  - Compute nxt = m - m_inc in W+1-bit signed.
  - If nxt <= m_min: m = m_min, then state = UP after that dwell.
  - Otherwise m = nxt.
  - Underflow below 0 clamps to m_min.
- Bound values: the top and bottom values are each held once per pass (no double dwell). m_min == m_max is legal: m is constant, and mode 0 finishes after one dwell.
- stop:
  - In any busy state: next edge state = IDLE, m = 0, enb = 0, busy = 0; done is NOT asserted.
  - In IDLE: no effect.
- start and stop together:
  - In IDLE: stop wins; no sweep and no err.
  - When busy: stop.
- stop coinciding with one-shot completion: stop wins, no done.
- Reset asserted mid-sweep: immediate return to reset values; no done.

Decomposition:
- Package sweep_pkg:
  - W and DW defaults.
  - state enum {IDLE, UP, DOWN} (2-bit encoding).
  - MODE_ONESHOT = 0, MODE_TRI = 1.
- Sub-module dwell_timer:
  - Ports: clk, rst_n, load, load_val[DW-1:0], expire.
  - Loadable down-counter that pulses `expire` at zero.
- The FSM and clamp arithmetic stay in sweep_ctrl.

Test Plan:
- Reset: assert rst_n = 0 asynchronously mid-sweep (mode 1, m = 20) -> m = 0, enb = 0, busy = 0 within the same cycle; no done pulse.
- One-shot sweep: m_min = 10, m_max = 30, m_inc = 10, dwell = 2, mode 0, start at cycle 0.
  - Cycles 1..6: m = 10, 10, 20, 20, 30, 30.
  - Cycle 7: m = 0, enb = 0, done = 1 (exactly one cycle).
- Continuous triangle: m_min = 0, m_max = 25, m_inc = 10, dwell = 0 (treated as 1), mode 1.
  - m sequence 0, 10, 20, 25, 15, 5, 0, 10, ...
  - enb stays 1; done never asserts.
- Overflow clamp: m_min = 2000, m_max = 2047, m_inc = 40, dwell = 1, mode 0 -> m = 2000, 2040, 2047, then IDLE with done = 1; no wrap to a small value.
- Abort and simultaneity:
  - stop during m = 20 of the one-shot run -> next cycle m = 0, enb = 0, busy = 0, done = 0.
  - start and stop together in IDLE -> stays IDLE, err = 0.
  - start while busy -> no change.
- Invalid config:
  - m_min = 50, m_max = 40 -> err = 1 for one cycle, busy stays 0.
  - m_inc = 0 -> same.
  - Changing m_max mid-sweep does not alter the latched sweep.
